// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-ported memory between
// instruction fetch and load/store with data priority and fetch cancel.
module unified_mem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_abort,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state;
    logic          owner_d;
    logic          we;
    logic          cancel;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;

    logic arb;
    logic served_d;
    logic served_f;
    logic grant_d;
    logic grant_f;

    // A cancelled fetch leaves if_req free to carry a fresh request in DONE.
    always_comb begin
        arb      = (state == IDLE) || (state == DONE);
        served_d = (state == DONE) && owner_d;
        served_f = (state == DONE) && !owner_d && !cancel;
        grant_d  = arb && d_req && !served_d;
        grant_f  = arb && !grant_d && if_req && !if_abort && !served_f;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            we         <= 1'b0;
            cancel     <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (grant_d) begin
                        state   <= ACCESS;
                        owner_d <= 1'b1;
                        we      <= d_we;
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        cnt     <= CNT_INIT;
                        cancel  <= 1'b0;
                    end else if (grant_f) begin
                        state   <= ACCESS;
                        owner_d <= 1'b0;
                        we      <= 1'b0;
                        addr_q  <= if_addr;
                        wdata_q <= '0;
                        cnt     <= CNT_INIT;
                        cancel  <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!owner_d && if_abort)
                        cancel <= 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                        if (!we) begin
                            if (owner_d)
                                d_rdata_q <= mem_rdata;
                            else if (!cancel && !if_abort)
                                if_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = (state == ACCESS) && !we;
    assign mem_write = (state == ACCESS) && we;
    assign busy      = (state != IDLE);
    assign if_ready  = (state == DONE) && !owner_d && !cancel;
    assign d_ready   = (state == DONE) && owner_d;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed scenarios and random traffic
// checked each cycle against a cycle-number based transaction model.
module tb_unified_mem_arbiter;

    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_abort;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        busy;

    unified_mem_arbiter #(.MEM_LATENCY(ML)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_ifr = 0;
    int n_dr = 0;

    // Transaction model: current access occupies cycles start..start+ML-1,
    // completion is reported in cycle start+ML.
    logic        cur_valid;
    logic        cur_d;
    logic        cur_we;
    logic        cur_cancel;
    int          start;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        cur_valid    = 1'b0;
        cur_d        = 1'b0;
        cur_we       = 1'b0;
        cur_cancel   = 1'b0;
        start        = 0;
        last_addr    = '0;
        last_wdata   = '0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic ab, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd,
                         input logic [31:0] mr);
        if_req    = ir;
        if_addr   = ia;
        if_abort  = ab;
        d_req     = dr;
        d_we      = dw;
        d_addr    = da;
        d_wdata   = dwd;
        mem_rdata = mr;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, ".mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, ".if_ready"}, 32'(if_ready), 32'd0);
        chk({tag, ".d_ready"}, 32'(d_ready), 32'd0);
        chk({tag, ".mem_addr"}, mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, ".if_rdata"}, if_rdata, 32'd0);
        chk({tag, ".d_rdata"}, d_rdata, 32'd0);
    endtask

    // One cycle: compare at negedge, advance model with this cycle's inputs.
    task automatic step();
        logic ina;
        logic indn;
        logic xd;
        logic xf;
        @(negedge clk);
        ina  = cur_valid && cyc >= start && cyc < start + ML;
        indn = cur_valid && cyc == start + ML;
        chk("busy", 32'(busy), 32'(ina || indn));
        chk("mem_read", 32'(mem_read), 32'(ina && !cur_we));
        chk("mem_write", 32'(mem_write), 32'(ina && cur_we));
        chk("mem_addr", mem_addr, last_addr);
        chk("mem_wdata", mem_wdata, last_wdata);
        chk("if_ready", 32'(if_ready), 32'(indn && !cur_d && !cur_cancel));
        chk("d_ready", 32'(d_ready), 32'(indn && cur_d));
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        n_ifr += int'(if_ready);
        n_dr  += int'(d_ready);
        if (ina) begin
            if (!cur_d && if_abort) cur_cancel = 1'b1;
            if (cyc == start + ML - 1 && !cur_we) begin
                if (cur_d) exp_d_rdata = mem_rdata;
                else if (!cur_cancel) exp_if_rdata = mem_rdata;
            end
        end else begin
            xd = indn && cur_d;
            xf = indn && !cur_d && !cur_cancel;
            if (d_req && !xd) begin
                cur_valid  = 1'b1;
                cur_d      = 1'b1;
                cur_we     = d_we;
                cur_cancel = 1'b0;
                start      = cyc + 1;
                last_addr  = d_addr;
                last_wdata = d_wdata;
            end else if (if_req && !if_abort && !xf) begin
                cur_valid  = 1'b1;
                cur_d      = 1'b0;
                cur_we     = 1'b0;
                cur_cancel = 1'b0;
                start      = cyc + 1;
                last_addr  = if_addr;
                last_wdata = '0;
            end else begin
                cur_valid = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a;
        int b;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        mreset();
        @(posedge clk);
        #1;
        chk_zero("por");
        reset = 1'b1;

        // Single fetch
        drive(1, 32'h0040_0000, 0, 0, 0, 0, 0, 32'h2008_0005);
        step();
        step();
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h2008_0005);
        step();
        chk("t2.if_rdata", if_rdata, 32'h2008_0005);
        step();

        // Contention: data first, then fetch
        drive(1, 32'h0040_0004, 0, 1, 0, 32'h1001_0000, 0, 32'h0000_002A);
        step();
        step();
        step();
        d_req = 1'b0;
        mem_rdata = 32'h0000_0013;
        step();
        step();
        step();
        if_req = 1'b0;
        step();
        chk("t3.d_rdata", d_rdata, 32'h0000_002A);
        chk("t3.if_rdata", if_rdata, 32'h0000_0013);

        // Store
        drive(0, 0, 0, 1, 1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h5555_5555);
        step();
        chk("t4.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t4.mem_write", 32'(mem_write), 32'd1);
        step();
        step();
        d_req = 1'b0;
        step();
        chk("t4.d_rdata", d_rdata, 32'h0000_002A);

        // Aborted fetch followed by a new fetch in DONE
        a = n_ifr;
        drive(1, 32'h0040_0008, 0, 0, 0, 0, 0, 32'h1111_1111);
        step();
        if_req = 1'b0;
        if_abort = 1'b1;
        step();
        if_abort = 1'b0;
        step();
        drive(1, 32'h0040_000C, 0, 0, 0, 0, 0, 32'h2222_2222);
        step();
        step();
        step();
        if_req = 1'b0;
        step();
        chk("t5.if_ready_count", 32'(n_ifr - a), 32'd1);
        chk("t5.if_rdata", if_rdata, 32'h2222_2222);

        // Continuous contention: strict alternation
        a = n_ifr;
        b = n_dr;
        drive(1, 32'h0040_0010, 0, 1, 0, 32'h1001_0008, 0, 32'h3333_3333);
        for (int i = 0; i < 19; i++) step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t6.if_ready_count", 32'(n_ifr - a), 32'd3);
        chk("t6.d_ready_count", 32'(n_dr - b), 32'd3);

        // Asynchronous reset in the middle of an access
        drive(1, 32'h0040_0020, 0, 0, 0, 0, 0, 32'h4444_4444);
        step();
        step();
        reset = 1'b0;
        if_req = 1'b0;
        #1;
        chk_zero("midrst");
        mreset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if_req    = ($urandom_range(0, 2) != 0);
            if_addr   = $urandom;
            if_abort  = ($urandom_range(0, 7) == 0);
            d_req     = ($urandom_range(0, 2) == 0);
            d_we      = $urandom_range(0, 1) == 1;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            mem_rdata = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
